// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI bus arbiter: FSM state encoding,
// burst byte counter type and the data/length field widths.
package spi_arb_pkg;

  localparam int LEN_W  = 2;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    HOLD
  } arb_state_e;

  typedef logic [LEN_W-1:0] byte_cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set req bit searching upward
// from pointer+1 with wrap-around. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // off runs 1..NUM_REQ so the requester at pointer is considered last
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = PTR_W'((int'(pointer) + off) % NUM_REQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one byte-wide SPI master between NUM_REQ requesters: round-robin
// grant, one ss_n window per burst with setup/hold gaps, byte handshake.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_tx_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        tx_pop,
  output logic [DATA_W-1:0]         rx_data,
  output logic [NUM_REQ-1:0]        rx_valid,
  output logic [NUM_REQ-1:0]        xfer_done,
  input  logic                      m_ready,
  output logic                      m_start,
  output logic [DATA_W-1:0]         m_tx_data,
  input  logic                      m_done,
  input  logic [DATA_W-1:0]         m_rx_data,
  output logic                      ss_n
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam logic [GAP_W-1:0] SETUP_LOAD = GAP_W'(CS_SETUP - 1);
  localparam logic [GAP_W-1:0] HOLD_LOAD  = GAP_W'(CS_HOLD - 1);

  arb_state_e          state_reg, state_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  byte_cnt_t           cnt_reg, cnt_next;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic [PTR_W-1:0]    pointer_reg, pointer_next;
  logic                ss_n_reg, ss_n_next;
  logic [NUM_REQ-1:0]  tx_pop_reg, tx_pop_next;
  logic [NUM_REQ-1:0]  rx_valid_reg, rx_valid_next;
  logic [NUM_REQ-1:0]  xfer_done_reg, xfer_done_next;
  logic                m_start_reg, m_start_next;
  logic [DATA_W-1:0]   m_tx_data_reg, m_tx_data_next;
  logic [DATA_W-1:0]   rx_data_reg, rx_data_next;

  logic [NUM_REQ-1:0]  arb_gnt;
  byte_cnt_t           len_term [NUM_REQ];
  logic [DATA_W-1:0]   tx_term  [NUM_REQ];
  byte_cnt_t           win_len;
  logic [DATA_W-1:0]   sel_tx;
  logic [PTR_W-1:0]    served_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req     (req),
    .pointer (pointer_reg),
    .en      (state_reg == IDLE),
    .gnt     (arb_gnt)
  );

  // Length is taken from the arbiter's fresh pick; data from the held grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign len_term[gi] = req_len[gi*LEN_W +: LEN_W] & {LEN_W{arb_gnt[gi]}};
    assign tx_term[gi]  = req_tx_data[gi*DATA_W +: DATA_W] & {DATA_W{grant_reg[gi]}};
  end

  always_comb begin
    win_len    = '0;
    sel_tx     = '0;
    served_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_len = win_len | len_term[i];
      sel_tx  = sel_tx | tx_term[i];
      if (grant_reg[i]) served_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      cnt_reg       <= '0;
      gap_reg       <= '0;
      pointer_reg   <= PTR_W'(NUM_REQ - 1);
      ss_n_reg      <= 1'b1;
      tx_pop_reg    <= '0;
      rx_valid_reg  <= '0;
      xfer_done_reg <= '0;
      m_start_reg   <= 1'b0;
      m_tx_data_reg <= '0;
      rx_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      cnt_reg       <= cnt_next;
      gap_reg       <= gap_next;
      pointer_reg   <= pointer_next;
      ss_n_reg      <= ss_n_next;
      tx_pop_reg    <= tx_pop_next;
      rx_valid_reg  <= rx_valid_next;
      xfer_done_reg <= xfer_done_next;
      m_start_reg   <= m_start_next;
      m_tx_data_reg <= m_tx_data_next;
      rx_data_reg   <= rx_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    cnt_next       = cnt_reg;
    gap_next       = gap_reg;
    pointer_next   = pointer_reg;
    ss_n_next      = ss_n_reg;
    m_tx_data_next = m_tx_data_reg;
    rx_data_next   = rx_data_reg;
    tx_pop_next    = '0;
    rx_valid_next  = '0;
    xfer_done_next = '0;
    m_start_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|arb_gnt) begin
          grant_next = arb_gnt;
          cnt_next   = win_len;
          ss_n_next  = 1'b0;
          gap_next   = SETUP_LOAD;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (gap_reg == '0) state_next = START;
        else               gap_next   = gap_reg - GAP_W'(1);
      end
      START: begin
        if (m_ready) begin
          m_start_next   = 1'b1;
          m_tx_data_next = sel_tx;
          tx_pop_next    = grant_reg;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (m_done) begin
          rx_data_next  = m_rx_data;
          rx_valid_next = grant_reg;
          if (cnt_reg != '0) begin
            cnt_next   = cnt_reg - byte_cnt_t'(1);
            state_next = START;
          end else begin
            gap_next   = HOLD_LOAD;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (gap_reg == '0) begin
          ss_n_next      = 1'b1;
          xfer_done_next = grant_reg;
          grant_next     = '0;
          pointer_next   = served_idx;
          state_next     = IDLE;
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant     = grant_reg;
  assign tx_pop    = tx_pop_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign xfer_done = xfer_done_reg;
  assign m_start   = m_start_reg;
  assign m_tx_data = m_tx_data_reg;
  assign ss_n      = ss_n_reg;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench: requester and SPI master models around the arbiter,
// with a transaction-level round-robin reference model.
module tb_spi_bus_arbiter;

  localparam int NR  = 2;
  localparam int CSS = 2;
  localparam int CSH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*2-1:0] req_len;
  logic [NR*8-1:0] req_tx_data;
  logic [NR-1:0]   grant, tx_pop, rx_valid, xfer_done;
  logic [7:0]      rx_data, m_tx_data, m_rx_data;
  logic            m_ready, m_start, m_done, ss_n;

  logic            mst_idle, mst_done, spur_done, stall;
  logic [7:0]      mst_rx, junk_rx, rx_key;
  int              lat_lo, lat_hi;
  logic [NR-1:0]   drop;
  logic [NR*2-1:0] len_flip;

  assign m_ready   = mst_idle & ~stall;
  assign m_done    = mst_done | spur_done;
  assign m_rx_data = mst_done ? mst_rx : junk_rx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ptr_model;

  int         blen_q [NR][$];
  logic [7:0] tx_q   [NR][$];
  int         plan_len   [NR][$];
  logic [7:0] plan_bytes [NR][$];
  int obs_gnt[$], obs_start[$], obs_rx[$], obs_done[$];
  int g_t[$], st_t[$], rx_t[$], dn_t[$];
  logic [NR-1:0] prev_grant;

  spi_bus_arbiter #(.NUM_REQ(NR), .CS_SETUP(CSS), .CS_HOLD(CSH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_tx_data(req_tx_data),
    .grant(grant), .tx_pop(tx_pop), .rx_data(rx_data), .rx_valid(rx_valid),
    .xfer_done(xfer_done), .m_ready(m_ready), .m_start(m_start), .m_tx_data(m_tx_data),
    .m_done(m_done), .m_rx_data(m_rx_data), .ss_n(ss_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Requesters: present front byte / front burst length, advance on pops.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rst === 1'b0) begin
        if (tx_pop[i] && tx_q[i].size() > 0) void'(tx_q[i].pop_front());
        if (xfer_done[i] && blen_q[i].size() > 0) void'(blen_q[i].pop_front());
      end
      req[i] = (blen_q[i].size() > 0) && !drop[i];
      req_len[2*i +: 2] = ((blen_q[i].size() > 0) ? 2'(blen_q[i][0] - 1) : 2'b00) ^ len_flip[2*i +: 2];
      req_tx_data[8*i +: 8] = (tx_q[i].size() > 0) ? tx_q[i][0] : 8'h00;
    end
  end

  // SPI master: takes a byte on m_start, answers byte^rx_key after a random latency.
  initial begin
    logic [7:0] b;
    mst_idle = 1'b1;
    mst_done = 1'b0;
    mst_rx   = 8'h00;
    forever begin
      @(negedge clk);
      mst_done = 1'b0;
      if (m_start === 1'b1 && rst === 1'b0) begin
        b        = m_tx_data;
        mst_idle = 1'b0;
        repeat ($urandom_range(lat_hi, lat_lo)) @(negedge clk);
        mst_rx   = b ^ rx_key;
        mst_done = 1'b1;
        mst_idle = 1'b1;
      end
    end
  end

  // Monitor: per-cycle invariants plus event/timestamp capture.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_grant <= '0;
    end else begin
      check("ss_n_vs_grant", 32'(ss_n), 32'(grant == '0));
      check("grant_onehot", 32'($onehot0(grant)), 32'd1);
      check("tx_pop_vs_start", 32'(tx_pop), 32'(m_start ? grant : '0));
      check("rx_valid_in_grant", 32'(rx_valid & ~grant), 32'd0);
      if (prev_grant == '0 && grant != '0) begin
        obs_gnt.push_back(idx_of(grant));
        g_t.push_back(cyc);
      end
      if (m_start) begin
        obs_start.push_back(idx_of(grant) * 256 + int'(m_tx_data));
        st_t.push_back(cyc);
      end
      if (rx_valid != '0) begin
        obs_rx.push_back(idx_of(rx_valid) * 256 + int'(rx_data));
        rx_t.push_back(cyc);
      end
      if (xfer_done != '0) begin
        obs_done.push_back(idx_of(xfer_done));
        dn_t.push_back(cyc);
      end
      prev_grant <= grant;
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < NR; i++) begin
      plan_len[i].delete();
      plan_bytes[i].delete();
    end
  endtask

  task automatic add_burst(input int r, input int n);
    plan_len[r].push_back(n);
    for (int k = 0; k < n; k++) plan_bytes[r].push_back(8'($urandom));
  endtask

  function automatic bit busy();
    bit b = !ss_n || !mst_idle;
    for (int i = 0; i < NR; i++) if (blen_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  // Load the plan, derive the expected transaction stream, run, compare.
  task automatic run_plan(input bit chk_setup);
    int pl[NR][$];
    int bpos[NR];
    int exp_gnt[$], exp_blen[$], exp_start[$], exp_rx[$];
    int w, n, k, t;
    logic [7:0] b;
    obs_gnt.delete(); obs_start.delete(); obs_rx.delete(); obs_done.delete();
    g_t.delete(); st_t.delete(); rx_t.delete(); dn_t.delete();
    for (int i = 0; i < NR; i++) begin
      pl[i] = plan_len[i];
      bpos[i] = 0;
    end
    forever begin
      w = -1;
      for (int off = 1; off <= NR; off++)
        if (w < 0 && pl[(ptr_model + off) % NR].size() > 0) w = (ptr_model + off) % NR;
      if (w < 0) break;
      n = pl[w].pop_front();
      exp_gnt.push_back(w);
      exp_blen.push_back(n);
      for (int j = 0; j < n; j++) begin
        b = plan_bytes[w][bpos[w]];
        bpos[w]++;
        exp_start.push_back(w * 256 + int'(b));
        exp_rx.push_back(w * 256 + int'(b ^ rx_key));
      end
      ptr_model = w;
    end
    for (int i = 0; i < NR; i++) begin
      blen_q[i] = plan_len[i];
      tx_q[i] = plan_bytes[i];
    end
    @(negedge clk);
    t = 0;
    while (busy() && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("plan_timeout", 32'(t < 4000), 32'd1);
    repeat (3) @(negedge clk);
    check("n_grants", obs_gnt.size(), exp_gnt.size());
    check("n_starts", obs_start.size(), exp_start.size());
    check("n_rx", obs_rx.size(), exp_rx.size());
    check("n_done", obs_done.size(), exp_gnt.size());
    if (obs_gnt.size() == exp_gnt.size() && obs_start.size() == exp_start.size() &&
        obs_rx.size() == exp_rx.size() && obs_done.size() == exp_gnt.size()) begin
      foreach (exp_start[j]) begin
        check("tx_byte", obs_start[j], exp_start[j]);
        check("rx_byte", obs_rx[j], exp_rx[j]);
      end
      k = 0;
      foreach (exp_gnt[bi]) begin
        n = exp_blen[bi];
        check("grant_order", obs_gnt[bi], exp_gnt[bi]);
        check("done_owner", obs_done[bi], exp_gnt[bi]);
        if (chk_setup) check("setup_gap", st_t[k] - g_t[bi], CSS + 1);
        for (int j = 1; j < n; j++) check("byte_gap", st_t[k+j] - rx_t[k+j-1], 1);
        check("hold_gap", dn_t[bi] - rx_t[k+n-1], CSH);
        if (bi > 0) check("ss_high_gap", g_t[bi] - dn_t[bi-1], 1);
        k += n;
      end
      $display("[TB] plan: %0d bursts %0d bytes, grants checked", exp_gnt.size(), exp_start.size());
    end
  endtask

  initial begin
    int t, saved, total;
    rst = 1'b1; stall = 1'b0; spur_done = 1'b0; drop = '0; len_flip = '0;
    rx_key = 8'h00; junk_rx = 8'h00; lat_lo = 1; lat_hi = 1; ptr_model = NR - 1;
    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(ss_n), 32'd1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_pulses", 32'({tx_pop, rx_valid, xfer_done, m_start}), 32'd0);
    check("rst_data", 32'({rx_data, m_tx_data}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 1-byte loopback transfer.
    clear_plan();
    plan_len[0].push_back(1);
    plan_bytes[0].push_back(8'hA5);
    lat_lo = 3; lat_hi = 3;
    run_plan(1'b1);
    check("t1_rx_data", 32'(rx_data), 32'hA5);
    if (g_t.size() == 1 && dn_t.size() == 1) check("t1_ss_low", dn_t[0] - g_t[0], CSS + CSH + 3 + 2);

    // 4-byte burst from requester 1.
    clear_plan();
    plan_len[1].push_back(4);
    plan_bytes[1] = '{8'h11, 8'h22, 8'h33, 8'h44};
    rx_key = 8'h3C; lat_lo = 1; lat_hi = 3;
    run_plan(1'b1);

    // Continuous contention: expect 0,1,0,1.
    clear_plan();
    add_burst(0, 2); add_burst(0, 1);
    add_burst(1, 1); add_burst(1, 3);
    run_plan(1'b1);

    // m_done outside WAIT must be ignored.
    @(negedge clk);
    saved = int'(rx_data);
    junk_rx = ~rx_data;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_rx_valid", 32'(rx_valid), 32'd0);
    check("spur_rx_data", 32'(rx_data), saved);

    // m_ready held low for 20 clocks in START.
    clear_plan();
    add_burst(0, 1);
    stall = 1'b1;
    fork
      run_plan(1'b0);
      begin
        t = 0;
        while (grant == '0 && t < 50) begin @(negedge clk); t++; end
        check("stall_grant_seen", 32'(grant != '0), 32'd1);
        repeat (20) begin
          @(negedge clk);
          check("stall_no_start", 32'(m_start), 32'd0);
          check("stall_ss_low", 32'(ss_n), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall_release_start", 32'(m_start), 32'd1);
      end
    join

    // req dropped and req_len changed mid-burst: 3 bytes still go out.
    clear_plan();
    add_burst(0, 3);
    fork
      run_plan(1'b1);
      begin
        t = 0;
        while (m_start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        drop[0] = 1'b1;
        len_flip[1:0] = 2'b11;
        t = 0;
        while (xfer_done == '0 && t < 200) begin @(negedge clk); t++; end
        drop = '0;
        len_flip = '0;
      end
    join

    // Reset asserted during WAIT.
    blen_q[0] = '{4};
    tx_q[0] = '{8'h81, 8'h82, 8'h83, 8'h84};
    blen_q[1] = '{1};
    tx_q[1] = '{8'h99};
    t = 0;
    while (m_start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("rstw_reached_wait", 32'(m_start), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_ss_n", 32'(ss_n), 32'd1);
    check("rstw_grant", 32'(grant), 32'd0);
    check("rstw_pulses", 32'({tx_pop, rx_valid, xfer_done, m_start}), 32'd0);
    check("rstw_data", 32'({rx_data, m_tx_data}), 32'd0);
    for (int i = 0; i < NR; i++) begin
      blen_q[i].delete();
      tx_q[i].delete();
    end
    t = 0;
    while ((t < 6 || !mst_idle) && t < 40) begin
      @(negedge clk);
      check("rstw_no_done", 32'(xfer_done), 32'd0);
      t++;
    end
    rst = 1'b0;
    ptr_model = NR - 1;
    @(negedge clk);
    clear_plan();
    add_burst(1, 2);
    add_burst(0, 1);
    run_plan(1'b1);
    if (obs_gnt.size() > 0) check("rstw_first_winner", obs_gnt[0], 0);

    // Randomized plans.
    for (int r = 0; r < 6; r++) begin
      clear_plan();
      rx_key = 8'($urandom);
      lat_lo = 1;
      lat_hi = $urandom_range(5, 1);
      total = 0;
      for (int i = 0; i < NR; i++) begin
        for (int k = 0; k < $urandom_range(3, 0); k++) begin
          add_burst(i, $urandom_range(4, 1));
          total++;
        end
      end
      if (total == 0) add_burst($urandom_range(NR - 1, 0), $urandom_range(4, 1));
      run_plan(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares one byte-wide SPI master engine between `NUM_REQ` on-chip requesters, such as the button-driven transmit logic and the FND readback path inside the SPI top level. It grants requesters round-robin and latches each winner's burst length. It then frames the whole burst with one slave-select assertion, with programmable setup and hold gaps, and sequences the master byte-by-byte through a start/done handshake. Received bytes are returned to the granted requester.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters.
- `CS_SETUP`, default 2: clocks from `ss_n` falling to the first `m_start`. Minimum 1.
- `CS_HOLD`, default 2: clocks from the last `m_done` to `ss_n` rising. Minimum 1.

Ports (all signals synchronous to `clk`):
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in NUM_REQ: per-requester transfer request, level.
- `req_len` in NUM_REQ*2: per-requester burst length. Slice i covers bits [2i+1:2i]; the burst is the value plus 1 byte (1..4 bytes).
- `req_tx_data` in NUM_REQ*8: per-requester next transmit byte. Slice i covers bits [8i+7:8i].
- `grant` out NUM_REQ: one-hot; the owner of the current burst.
- `tx_pop` out NUM_REQ: 1-cycle pulse telling the requester its current byte was consumed.
- `rx_data` out 8: last received byte, shared by all requesters.
- `rx_valid` out NUM_REQ: 1-cycle pulse qualifying `rx_data` for the granted requester.
- `xfer_done` out NUM_REQ: 1-cycle pulse when the burst has finished and `ss_n` has risen.
- `m_ready` in 1: SPI master is idle.
- `m_start` out 1: 1-cycle start pulse to the SPI master.
- `m_tx_data` out 8: byte sent to the SPI master, held valid while `m_start` is high.
- `m_done` in 1: 1-cycle pulse from the SPI master; the byte is complete.
- `m_rx_data` in 8: byte received by the SPI master, valid while `m_done` is high.
- `ss_n` out 1: slave select, active-low.

## Operation
- The FSM states are `IDLE`, `SETUP`, `START`, `WAIT`, `HOLD`.
- **IDLE.** If any `req` bit is high, the arbiter picks a winner and the FSM moves to `SETUP`. In that same transition it:
  - registers `grant`,
  - latches the winner's `req_len` into the byte counter,
  - drives `ss_n` to 0,
  - loads the gap counter with `CS_SETUP-1`.
- **SETUP.** The gap counter counts down; at 0 the FSM moves to `START`.
- **START.** The FSM waits for `m_ready`=1. When it is high, it pulses `m_start`, drives `m_tx_data` from the granted slice of `req_tx_data`, pulses `tx_pop[grant]`, and moves to `WAIT`.
- **WAIT.** On `m_done` the FSM captures `m_rx_data` into `rx_data` and pulses `rx_valid[grant]`.
  - If the byte counter is nonzero, it decrements the counter and moves to `START`.
  - Otherwise it loads the gap counter with `CS_HOLD-1` and moves to `HOLD`.
- **HOLD.** The gap counter counts down. At 0 the FSM:
  - sets `ss_n` to 1,
  - pulses `xfer_done[grant]`,
  - clears `grant`,
  - updates the round-robin pointer to the index just served,
  - moves to `IDLE`.
- **Round-robin rule.**
  - The winner is the first `req` bit set, searching from `pointer+1` upward with wrap-around.
  - The pointer resets to `NUM_REQ-1`, so requester 0 wins the first contest.
- Once a burst is granted it runs to completion:
  - deasserting `req` mid-burst has no effect;
  - `req_len` changes after the latch are ignored.
- `m_done` is ignored in every state except `WAIT`.
- A requester that keeps `req` high is re-arbitrated in `IDLE` after its `xfer_done`. It cannot win twice in a row while any other `req` bit is set.

## Timing
- **Reset values:**
  - `ss_n`=1;
  - `grant`, `tx_pop`, `rx_valid`, `xfer_done`, `m_start` = 0;
  - `rx_data`=0, `m_tx_data`=0;
  - state `IDLE`; pointer `NUM_REQ-1`.
- Reset asserted mid-burst forces all of the above on the same edge. No `xfer_done` is issued.
- All outputs are registered.
- `req` sampled high in `IDLE` at edge N gives `grant` and `ss_n`=0 visible after edge N.
- The first `m_start` comes at edge N+`CS_SETUP`+1, provided `m_ready` was high.
- `m_done` at edge M gives `rx_valid` and `rx_data` after edge M.
- For the next byte, `m_start` is no earlier than edge M+1, then waits for `m_ready`.
- After the final `m_done` at edge M, `ss_n` rises and `xfer_done` pulses after edge M+`CS_HOLD`.
- The earliest new grant is at edge M+`CS_HOLD`+1. This gives a minimum `ss_n` high time of 1 clock.
- `tx_pop` coincides with `m_start`. The requester must present its next byte by the following `START` state, at least 1 clock later.

## Structure
- Package `spi_arb_pkg` holds:
  - the state enum `arb_state_e`,
  - the `byte_cnt_t` (2-bit) typedef,
  - the localparams for the length field width (2) and the data width (8).
- Sub-module `rr_arbiter` takes `req`, `pointer` and `en` and returns a one-hot `gnt`. It is combinational with a registered pointer update. It is instantiated once.
- The top-level `spi_bus_arbiter` holds the FSM, the byte and gap counters, and the data muxing.

## Test plan
- Single request, 1 byte: `req`=01, `req_len[1:0]`=0, `req_tx_data[7:0]`=8'hA5, with loopback `m_rx_data`=8'hA5. Required: one `m_start` carrying `m_tx_data`=8'hA5, then `rx_valid`=01 with `rx_data`=8'hA5. `ss_n` must be low for `CS_SETUP`+master time+`CS_HOLD` clocks, then `xfer_done`=01.
- Burst of 4: requester 1 with `req_len`=3 and tx bytes 11, 22, 33, 44. Required: 4 `m_start` pulses in that byte order, 4 `tx_pop[1]` pulses, a single `ss_n` low window, and 1 `xfer_done`.
- Contention: `req`=11 held continuously. Required grant order 01, 10, 01, 10, with an `ss_n` high gap of at least 1 clock between bursts.
- `m_ready` held low for 20 clocks in `START`. Required: `m_start` stays 0 and `ss_n` stays low; `m_start` fires the clock after `m_ready` rises.
- `req` dropped and `req_len` changed mid-burst (latched len=2). Required: all 3 bytes are still sent.
- `rst` asserted during `WAIT`. Required: `ss_n`=1 and all pulse outputs 0 immediately, no `xfer_done`. After release, requester 0 wins first.
